// File: rtl/jts16_bank_arb.sv
// Three-requester read arbiter for one SDRAM bank with a one-word cache per slot.
// Slots: 0 = sound CPU ROM, 1 = ADPCM ROM, 2 = spare ROM client.
//
// Handshake towards the bank: ba_rd rises with ba_addr and both hold steady
// until ba_ack is seen; ba_rd then drops. Data is taken from data_read on the
// single cycle ba_rdy is high. ba_ack and ba_rdy together count as both events.
// Requester side: slotN_ok is high while slotN_cs is high and the cached word
// matches slotN_addr; there is no request/accept handshake on that side.
//
// dbg_state encoding: 0 = idle, 1 = waiting for ack, 2 = waiting for data.
module jts16_bank_arb #(
  parameter int AW = 22,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          downloading,
  input  logic          slot0_cs,
  input  logic [AW-1:0] slot0_addr,
  output logic [DW-1:0] slot0_data,
  output logic          slot0_ok,
  input  logic          slot1_cs,
  input  logic [AW-1:0] slot1_addr,
  output logic [DW-1:0] slot1_data,
  output logic          slot1_ok,
  input  logic          slot2_cs,
  input  logic [AW-1:0] slot2_addr,
  output logic [DW-1:0] slot2_data,
  output logic          slot2_ok,
  output logic [AW-1:0] ba_addr,
  output logic          ba_rd,
  input  logic          ba_ack,
  input  logic          ba_rdy,
  input  logic [DW-1:0] data_read,
  output logic [1:0]    dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_WAIT_RDY = 2'd2
  } state_t;

  state_t        r_state;
  logic          r_ba_rd;
  logic [AW-1:0] r_ba_addr;
  logic [1:0]    r_gnt;
  logic [1:0]    r_last;
  logic [2:0]    r_valid;
  logic [AW-1:0] r_tag  [3];
  logic [DW-1:0] r_data [3];

  logic [AW-1:0] w_req_addr [3];
  logic [2:0]    w_cs;
  logic [2:0]    w_ok;
  logic [2:0]    w_miss;
  logic          w_gnt_vld;
  logic [1:0]    w_gnt_idx;
  logic [1:0]    w_cand;
  logic [AW-1:0] w_gnt_addr;
  logic          w_fill;

  // Next slot index in the fixed 0 -> 1 -> 2 -> 0 rotation.
  function automatic logic [1:0] inc3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  assign w_req_addr[0] = slot0_addr;
  assign w_req_addr[1] = slot1_addr;
  assign w_req_addr[2] = slot2_addr;
  assign w_cs          = {slot2_cs, slot1_cs, slot0_cs};

  // Hit/miss per slot: a hit needs a valid entry whose tag matches the live address.
  always_comb begin
    w_ok   = '0;
    w_miss = '0;
    for (int i = 0; i < 3; i++) begin
      w_ok[i]   = w_cs[i] & r_valid[i] & (r_tag[i] == w_req_addr[i]);
      w_miss[i] = w_cs[i] & ~w_ok[i];
    end
  end

  // Round-robin pick: search starts at the slot after the last one granted.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = 2'd0;
    w_cand    = inc3(r_last);
    for (int k = 0; k < 3; k++) begin
      if (!w_gnt_vld && w_miss[w_cand]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_cand;
      end
      w_cand = inc3(w_cand);
    end
  end

  assign w_gnt_addr = w_req_addr[w_gnt_idx];
  assign w_fill     = ((r_state == ST_WAIT_ACK) && ba_ack && ba_rdy) ||
                      ((r_state == ST_WAIT_RDY) && ba_rdy);

  // Bank request FSM: issue on a miss, hold until ack, return to idle on data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      r_ba_rd   <= 1'b0;
      r_ba_addr <= '0;
      r_gnt     <= 2'd0;
      r_last    <= 2'd2;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!downloading && w_gnt_vld) begin
            r_ba_addr <= w_gnt_addr;
            r_gnt     <= w_gnt_idx;
            r_last    <= w_gnt_idx;
            r_ba_rd   <= 1'b1;
            r_state   <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (ba_ack) begin
            r_ba_rd <= 1'b0;
            r_state <= ba_rdy ? ST_IDLE : ST_WAIT_RDY;
          end
        end
        ST_WAIT_RDY: begin
          if (ba_rdy) r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_ba_rd <= 1'b0;
        end
      endcase
    end
  end

  // Cache fill on read return; downloading invalidates every entry and discards fills.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      for (int i = 0; i < 3; i++) begin
        r_tag[i]  <= '0;
        r_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (downloading) begin
          r_valid[i] <= 1'b0;
        end else if (w_fill && (r_gnt == 2'(i))) begin
          r_valid[i] <= 1'b1;
          r_tag[i]   <= r_ba_addr;
          r_data[i]  <= data_read;
        end
      end
    end
  end

  assign slot0_ok   = w_ok[0];
  assign slot1_ok   = w_ok[1];
  assign slot2_ok   = w_ok[2];
  assign slot0_data = r_data[0];
  assign slot1_data = r_data[1];
  assign slot2_data = r_data[2];
  assign ba_rd      = r_ba_rd;
  assign ba_addr    = r_ba_addr;
  assign dbg_state  = r_state;

endmodule
